// File: rtl/silife_grid_wh_if.sv
// Row-access, status and tiling-edge signals of one silife_grid_wh tile.
// The grid drives the slave side; the host/neighbour logic drives the master side.
interface silife_grid_wh_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HEIGHT    = 8,
  parameter int unsigned GEN_WIDTH = 16,
  parameter int unsigned ROW_BITS  = $clog2(HEIGHT)
);
  logic                 enable;
  logic                 wrap;
  logic                 gen_clear;
  logic [ROW_BITS-1:0]  row_select;
  logic [WIDTH-1:0]     set_cells;
  logic [WIDTH-1:0]     clear_cells;
  logic [WIDTH-1:0]     cells;
  logic [GEN_WIDTH-1:0] generation;
  logic                 stable;
  logic [WIDTH-1:0]     i_n, i_s, o_n, o_s;
  logic [HEIGHT-1:0]    i_w, i_e, o_w, o_e;
  logic                 i_nw, i_ne, i_sw, i_se;
  logic                 o_nw, o_ne, o_sw, o_se;

  modport master (
    output enable, wrap, gen_clear, row_select, set_cells, clear_cells,
    output i_n, i_s, i_w, i_e, i_nw, i_ne, i_sw, i_se,
    input  cells, generation, stable,
    input  o_n, o_s, o_w, o_e, o_nw, o_ne, o_sw, o_se
  );

  modport slave (
    input  enable, wrap, gen_clear, row_select, set_cells, clear_cells,
    input  i_n, i_s, i_w, i_e, i_nw, i_ne, i_sw, i_se,
    output cells, generation, stable,
    output o_n, o_s, o_w, o_e, o_nw, o_ne, o_sw, o_se
  );
endinterface

// File: rtl/silife_grid_wh.sv
// WIDTH x HEIGHT Game-of-Life array (B3/S23) with row set/clear, generation counter and
// stable flag. Define SILIFE_WRAP_EN to honour the wrap (torus) input.
module silife_grid_wh #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HEIGHT    = 8,
  parameter int unsigned GEN_WIDTH = 16,
  parameter int unsigned ROW_BITS  = $clog2(HEIGHT)
) (
  input logic              clk,
  input logic              reset,
  silife_grid_wh_if.slave  bus
);
  localparam int unsigned N = WIDTH * HEIGHT;

  logic [N-1:0]                 cells_q, cells_d, step;
  logic [GEN_WIDTH-1:0]         gen_q, gen_d;
  logic                         stable_q, stable_d;
  logic                         row_valid, write_any;
  logic [WIDTH-1:0]             edge_n, edge_s, nb_n, nb_s;
  logic [HEIGHT-1:0]            edge_w, edge_e, nb_w, nb_e;
  logic                         nb_nw, nb_ne, nb_sw, nb_se;
  logic [HEIGHT+1:0][WIDTH+1:0] ext;
  logic [3:0]                   cnt;

  assign row_valid = 32'(bus.row_select) < HEIGHT;
  assign write_any = row_valid && ((|bus.set_cells) || (|bus.clear_cells));

  assign edge_n = cells_q[0 +: WIDTH];
  assign edge_s = cells_q[(HEIGHT-1)*WIDTH +: WIDTH];
  always_comb begin
    edge_w = '0;
    edge_e = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      edge_w[r] = cells_q[r*WIDTH];
      edge_e[r] = cells_q[r*WIDTH + WIDTH - 1];
    end
  end

`ifdef SILIFE_WRAP_EN
  // Torus: each edge sees the opposite edge of this same array.
  always_comb begin
    nb_n  = bus.i_n;
    nb_s  = bus.i_s;
    nb_w  = bus.i_w;
    nb_e  = bus.i_e;
    nb_nw = bus.i_nw;
    nb_ne = bus.i_ne;
    nb_sw = bus.i_sw;
    nb_se = bus.i_se;
    if (bus.wrap) begin
      nb_n  = edge_s;
      nb_s  = edge_n;
      nb_w  = edge_e;
      nb_e  = edge_w;
      nb_nw = cells_q[N-1];
      nb_ne = cells_q[(HEIGHT-1)*WIDTH];
      nb_sw = cells_q[WIDTH-1];
      nb_se = cells_q[0];
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = bus.wrap;
  assign nb_n  = bus.i_n;
  assign nb_s  = bus.i_s;
  assign nb_w  = bus.i_w;
  assign nb_e  = bus.i_e;
  assign nb_nw = bus.i_nw;
  assign nb_ne = bus.i_ne;
  assign nb_sw = bus.i_sw;
  assign nb_se = bus.i_se;
`endif

  // Array padded with a one-cell neighbour ring so every cell sees a full 3x3 window.
  always_comb begin
    ext = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        ext[r+1][c+1] = cells_q[r*WIDTH + c];
      end
      ext[r+1][0]       = nb_w[r];
      ext[r+1][WIDTH+1] = nb_e[r];
    end
    for (int c = 0; c < WIDTH; c++) begin
      ext[0][c+1]        = nb_n[c];
      ext[HEIGHT+1][c+1] = nb_s[c];
    end
    ext[0][0]              = nb_nw;
    ext[0][WIDTH+1]        = nb_ne;
    ext[HEIGHT+1][0]       = nb_sw;
    ext[HEIGHT+1][WIDTH+1] = nb_se;
  end

  always_comb begin
    step = '0;
    cnt  = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        cnt = '0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) cnt = cnt + {3'b000, ext[r+dr][c+dc]};
          end
        end
        step[r*WIDTH + c] = (cnt == 4'd3) || (ext[r+1][c+1] && (cnt == 4'd2));
      end
    end
  end

  // Row writes override stepping; set beats clear on the same bit.
  always_comb begin
    cells_d = bus.enable ? step : cells_q;
    for (int r = 0; r < HEIGHT; r++) begin
      if (row_valid && (bus.row_select == ROW_BITS'(r))) begin
        cells_d[r*WIDTH +: WIDTH] = bus.set_cells |
                                    (cells_d[r*WIDTH +: WIDTH] & ~bus.clear_cells);
      end
    end
  end

  always_comb begin
    gen_d    = gen_q;
    stable_d = stable_q;
    if (bus.gen_clear)   gen_d = '0;
    else if (bus.enable) gen_d = gen_q + 1'b1;
    if (write_any)       stable_d = 1'b0;
    else if (bus.enable) stable_d = (step == cells_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cells_q  <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cells_q  <= cells_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    bus.cells = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      if (row_valid && (bus.row_select == ROW_BITS'(r))) bus.cells = cells_q[r*WIDTH +: WIDTH];
    end
  end

  assign bus.generation = gen_q;
  assign bus.stable     = stable_q;
  assign bus.o_n        = edge_n;
  assign bus.o_s        = edge_s;
  assign bus.o_w        = edge_w;
  assign bus.o_e        = edge_e;
  assign bus.o_nw       = cells_q[0];
  assign bus.o_ne       = cells_q[WIDTH-1];
  assign bus.o_sw       = cells_q[(HEIGHT-1)*WIDTH];
  assign bus.o_se       = cells_q[N-1];
endmodule
